// File: rtl/sha256_pkg.sv
// Shared SHA-256 types, constants and bit functions for the round engine.
// The build macro SHA256_FEEDFORWARD_EN is consumed by sha256_round_engine, not here.
package sha256_pkg;

    typedef logic [31:0] word_t;
    typedef word_t [7:0] state_t;   // [7] = a ... [0] = h, same order as the 256-bit buses

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } eng_state_t;

    localparam state_t IV = {
        32'h6a09e667, 32'hbb67ae85, 32'h3c6ef372, 32'ha54ff53a,
        32'h510e527f, 32'h9b05688c, 32'h1f83d9ab, 32'h5be0cd19
    };

    localparam word_t K_TABLE [64] = '{
        32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
        32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
        32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
        32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
        32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
        32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
        32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
        32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
    };

    function automatic word_t rotr(input word_t x, input int unsigned n);
        return (x >> n) | (x << (32 - n));
    endfunction

    function automatic word_t ch(input word_t e, input word_t f, input word_t g);
        return (e & f) ^ (~e & g);
    endfunction

    function automatic word_t maj(input word_t a, input word_t b, input word_t c);
        return (a & b) ^ (a & c) ^ (b & c);
    endfunction

    function automatic word_t big_sigma0(input word_t x);
        return rotr(x, 2) ^ rotr(x, 13) ^ rotr(x, 22);
    endfunction

    function automatic word_t big_sigma1(input word_t x);
        return rotr(x, 6) ^ rotr(x, 11) ^ rotr(x, 25);
    endfunction

    function automatic word_t small_sigma0(input word_t x);
        return rotr(x, 7) ^ rotr(x, 18) ^ (x >> 3);
    endfunction

    function automatic word_t small_sigma1(input word_t x);
        return rotr(x, 17) ^ rotr(x, 19) ^ (x >> 10);
    endfunction

endpackage

// File: rtl/sha256_round.sv
// One combinational SHA-256 round: working variables a..h in, updated a..h out.
module sha256_round
    import sha256_pkg::*;
(
    input  logic [255:0] st_in,
    input  logic [31:0]  k,
    input  logic [31:0]  w,
    output logic [255:0] st_out
);

    word_t a, b, c, d, e, f, g, h;
    word_t t1, t2;

    assign {a, b, c, d, e, f, g, h} = st_in;

    always_comb begin
        t1     = h + big_sigma1(e) + ch(e, f, g) + k + w;
        t2     = big_sigma0(a) + maj(a, b, c);
        st_out = {t1 + t2, a, b, c, d + t1, e, f, g};
    end

endmodule

// File: rtl/sha256_round_engine.sv
// SHA-256 compression engine, ROUNDS_PER_CYCLE rounds per clock.
// Build macro SHA256_FEEDFORWARD_EN adds the chaining value into the digest.
//
// state   | meaning
// --------+-----------------------------------------------
// ST_IDLE | waiting for a block, in_ready high
// ST_RUN  | applying R rounds per cycle, rounds 0..63
// ST_DONE | digest held, out_valid high until out_ready
module sha256_round_engine
    import sha256_pkg::*;
#(
    parameter int ROUNDS_PER_CYCLE = 1
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [511:0] block,
    input  logic [255:0] state_in,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [255:0] digest
);

    localparam int         R        = ROUNDS_PER_CYCLE;
    localparam logic [5:0] STEP     = 6'(R);
    localparam logic [5:0] LAST_CNT = 6'(64 - R);

    if (!(R == 1 || R == 2 || R == 4 || R == 8 || R == 16)) begin : g_bad_rounds
        $error("sha256_round_engine: ROUNDS_PER_CYCLE must be 1, 2, 4, 8 or 16");
    end

    eng_state_t state_q, state_nxt;
    logic       accept, last_step;
    logic [5:0] rnd_q;
    state_t     work_q;
    state_t     digest_q, digest_nxt;
    word_t      w_win [16];
    word_t      w_ext [16 + R];
    state_t     st_chain [R + 1];

    always_ff @(posedge clk) begin
        if (reset) state_q <= ST_IDLE;
        else       state_q <= state_nxt;
    end

    always_comb begin
        state_nxt = state_q;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        accept    = 1'b0;
        last_step = 1'b0;
        case (state_q)
            ST_IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    accept    = 1'b1;
                    state_nxt = ST_RUN;
                end
            end
            ST_RUN: begin
                if (rnd_q == LAST_CNT) begin
                    last_step = 1'b1;
                    state_nxt = ST_DONE;
                end
            end
            ST_DONE: begin
                out_valid = 1'b1;
                if (out_ready) state_nxt = ST_IDLE;
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    // Extend the window by R words so the next window is w_ext[R .. R+15].
    always_comb begin
        for (int i = 0; i < 16; i++) w_ext[i] = w_win[i];
        for (int j = 0; j < R; j++) begin
            w_ext[16 + j] = small_sigma1(w_ext[14 + j]) + w_ext[9 + j]
                          + small_sigma0(w_ext[1 + j]) + w_ext[j];
        end
    end

    assign st_chain[0] = work_q;

    for (genvar j = 0; j < R; j++) begin : g_round
        sha256_round u_round (
            .st_in  (st_chain[j]),
            .k      (K_TABLE[rnd_q + 6'(j)]),
            .w      (w_ext[j]),
            .st_out (st_chain[j + 1])
        );
    end

`ifdef SHA256_FEEDFORWARD_EN
    state_t h_init_q;

    always_ff @(posedge clk) begin
        if (reset)       h_init_q <= '0;
        else if (accept) h_init_q <= state_in;
    end

    always_comb begin
        for (int i = 0; i < 8; i++) digest_nxt[i] = h_init_q[i] + st_chain[R][i];
    end
`else
    assign digest_nxt = st_chain[R];
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            work_q   <= '0;
            rnd_q    <= '0;
            digest_q <= '0;
            for (int i = 0; i < 16; i++) w_win[i] <= '0;
        end else if (accept) begin
            work_q <= state_in;
            rnd_q  <= '0;
            for (int i = 0; i < 16; i++) w_win[i] <= block[511 - 32*i -: 32];
        end else if (state_q == ST_RUN) begin
            work_q <= st_chain[R];
            rnd_q  <= rnd_q + STEP;
            for (int i = 0; i < 16; i++) w_win[i] <= w_ext[i + R];
            if (last_step) digest_q <= digest_nxt;
        end
    end

    assign digest = digest_q;

endmodule

// File: tb/tb_sha256_round_engine.sv
// Directed bench: one engine per legal ROUNDS_PER_CYCLE, all fed the same stimulus.
module tb_sha256_round_engine;

    localparam int NI = 5;

    localparam logic [255:0] IV_W = {
        32'h6a09e667, 32'hbb67ae85, 32'h3c6ef372, 32'ha54ff53a,
        32'h510e527f, 32'h9b05688c, 32'h1f83d9ab, 32'h5be0cd19
    };
    localparam logic [255:0] ABC_FULL   = 256'hba7816bf8f01cfea414140de5dae2223b00361a396177a9cb410ff61f20015ad;
    localparam logic [255:0] EMPTY_FULL = 256'he3b0c44298fc1c149afbf4c8996fb92427ae41e4649b934ca495991b7852b855;
    localparam logic [511:0] ABC_BLK    = {32'h61626380, 448'h0, 32'h00000018};
    localparam logic [511:0] EMPTY_BLK  = {32'h80000000, 480'h0};
    localparam logic [511:0] JUNK_BLK   = {16{32'hdeadbeef}};
    localparam logic [255:0] JUNK_ST    = {8{32'h12345678}};

    logic         clk = 1'b0;
    logic         reset;
    logic         in_valid;
    logic [511:0] block;
    logic [255:0] state_in;
    logic         out_ready;
    logic         in_ready_v  [NI];
    logic         out_valid_v [NI];
    logic [255:0] digest_v    [NI];

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    for (genvar g = 0; g < NI; g++) begin : g_dut
        sha256_round_engine #(.ROUNDS_PER_CYCLE(1 << g)) u_dut (
            .clk       (clk),
            .reset     (reset),
            .in_valid  (in_valid),
            .in_ready  (in_ready_v[g]),
            .block     (block),
            .state_in  (state_in),
            .out_valid (out_valid_v[g]),
            .out_ready (out_ready),
            .digest    (digest_v[g])
        );
    end

    task automatic check_val(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // Without feedforward the engine returns the raw working variables,
    // i.e. the full compression output minus the chaining value, per word.
    function automatic logic [255:0] expected_digest(input logic [255:0] full);
        logic [255:0] r;
        logic [255:0] iv;
        iv = IV_W;
`ifdef SHA256_FEEDFORWARD_EN
        r = full;
`else
        for (int i = 0; i < 8; i++) r[32*i +: 32] = full[32*i +: 32] - iv[32*i +: 32];
`endif
        return r;
    endfunction

    task automatic run_block(input string name, input logic [511:0] blk,
                             input logic [255:0] full, input bit junk_pulse);
        int           lat  [NI];
        bit           seen [NI];
        logic [255:0] dg   [NI];
        logic [255:0] exp;
        int           cyc;
        bit           all_seen;
        exp = expected_digest(full);
        for (int i = 0; i < NI; i++) begin
            seen[i] = 1'b0;
            lat[i]  = -1;
            dg[i]   = '0;
        end
        @(negedge clk);
        block     = blk;
        state_in  = IV_W;
        in_valid  = 1'b1;
        out_ready = 1'b0;
        @(posedge clk); #1;
        // Inputs change right after acceptance; the result must not care.
        in_valid = 1'b0;
        block    = JUNK_BLK;
        state_in = JUNK_ST;
        for (int i = 0; i < NI; i++)
            check_val($sformatf("%s_r%0d_in_ready_busy", name, 1 << i), 256'(in_ready_v[i]), 256'(0));
        cyc      = 0;
        all_seen = 1'b0;
        while (!all_seen && cyc < 80) begin
            in_valid = junk_pulse && (cyc == 2);
            @(posedge clk); #1;
            cyc++;
            all_seen = 1'b1;
            for (int i = 0; i < NI; i++) begin
                if (!seen[i] && out_valid_v[i]) begin
                    seen[i] = 1'b1;
                    lat[i]  = cyc;
                    dg[i]   = digest_v[i];
                end
                if (!seen[i]) all_seen = 1'b0;
            end
        end
        in_valid = 1'b0;
        for (int i = 0; i < NI; i++) begin
            check_val($sformatf("%s_r%0d_latency", name, 1 << i), 256'(lat[i]), 256'(64 >> i));
            check_val($sformatf("%s_r%0d_digest", name, 1 << i), dg[i], exp);
        end
        repeat (10) begin
            @(posedge clk); #1;
            for (int i = 0; i < NI; i++) begin
                check_val($sformatf("%s_r%0d_hold_digest", name, 1 << i), digest_v[i], exp);
                check_val($sformatf("%s_r%0d_hold_in_ready", name, 1 << i), 256'(in_ready_v[i]), 256'(0));
                check_val($sformatf("%s_r%0d_hold_out_valid", name, 1 << i), 256'(out_valid_v[i]), 256'(1));
            end
        end
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        for (int i = 0; i < NI; i++) begin
            check_val($sformatf("%s_r%0d_in_ready_after", name, 1 << i), 256'(in_ready_v[i]), 256'(1));
            check_val($sformatf("%s_r%0d_out_valid_after", name, 1 << i), 256'(out_valid_v[i]), 256'(0));
        end
    endtask

    task automatic check_reset_state(input string name);
        for (int i = 0; i < NI; i++) begin
            check_val($sformatf("%s_r%0d_in_ready", name, 1 << i), 256'(in_ready_v[i]), 256'(1));
            check_val($sformatf("%s_r%0d_out_valid", name, 1 << i), 256'(out_valid_v[i]), 256'(0));
            check_val($sformatf("%s_r%0d_digest", name, 1 << i), digest_v[i], 256'(0));
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog expired");
    end

    initial begin
        reset     = 1'b1;
        in_valid  = 1'b0;
        block     = '0;
        state_in  = '0;
        out_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check_reset_state("por");
        reset = 1'b0;

        run_block("abc", ABC_BLK, ABC_FULL, 1'b0);
        run_block("empty", EMPTY_BLK, EMPTY_FULL, 1'b0);
        run_block("abc_junk", ABC_BLK, ABC_FULL, 1'b1);

        // Reset in the middle of a run, with out_ready held high outside DONE.
        @(negedge clk);
        block     = ABC_BLK;
        state_in  = IV_W;
        in_valid  = 1'b1;
        @(posedge clk); #1;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        repeat (30) @(posedge clk);
        #1;
        check_val("mid_r1_still_running", 256'(out_valid_v[0]), 256'(0));
        out_ready = 1'b0;
        reset     = 1'b1;
        @(posedge clk); #1;
        check_reset_state("mid_reset");

        // Reset together with a handshake: the block must not be taken.
        in_valid = 1'b1;
        @(posedge clk); #1;
        reset    = 1'b0;
        in_valid = 1'b0;
        @(posedge clk); #1;
        for (int i = 0; i < NI; i++)
            check_val($sformatf("rst_hs_r%0d_in_ready", 1 << i), 256'(in_ready_v[i]), 256'(1));

        run_block("abc_after_reset", ABC_BLK, ABC_FULL, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
